// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU memory sequencer: access sizes, FSM states, byte width.
package lsu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } state_e;

    // Byte count of a request; illegal size yields 0 (no lanes touched).
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: positions store data/mask across two words and
// extracts, merges and extends load data from a {hi,lo} word pair.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic        uns,
    output logic [63:0] lane_data,
    output logic [7:0]  lane_mask,
    output logic        span,
    output logic [31:0] rdata
);

    logic [2:0]  n;
    logic [7:0]  base_mask;
    logic [31:0] raw;

    assign n         = size_bytes(size);
    assign span      = ({2'b00, off} + {1'b0, n}) > 4'd4;
    assign base_mask = (8'd1 << n) - 8'd1;
    assign lane_mask = base_mask << off;
    assign lane_data = {32'b0, wdata} << {off, 3'b000};
    assign raw       = 32'({hi, lo} >> {off, 3'b000});

    always_comb begin
        rdata = '0;
        case (size)
            SZ_B:    rdata = uns ? {24'b0, raw[BYTE_W-1:0]}
                             : {{24{raw[BYTE_W-1]}}, raw[BYTE_W-1:0]};
            SZ_H:    rdata = uns ? {16'b0, raw[2*BYTE_W-1:0]}
                             : {{16{raw[2*BYTE_W-1]}}, raw[2*BYTE_W-1:0]};
            SZ_W:    rdata = raw;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// LSU-to-data-memory sequencer: one request at a time, word-crossing accesses
// split into two aligned memory cycles, registered single-cycle response.
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata
);

    state_e            state, state_n;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;

    logic [ADDR_W-1:0] word0, word1;
    logic [31:0]       lo_in, hi_in;
    logic [63:0]       lane_data;
    logic [7:0]        lane_mask;
    logic              span;
    logic [31:0]       load_data;

    assign word0 = {addr_q[ADDR_W-1:2], 2'b00};
    assign word1 = word0 + ADDR_W'(4);

    // Bypass the live read data so the response register loads at the end of the
    // final access cycle; the upper word is zero when the access does not span.
    assign lo_in = (state == ACC0) ? mem_rdata : lo_q;
    assign hi_in = (state == ACC1) ? mem_rdata : 32'b0;

    lsu_lane_align u_align (
        .off       (addr_q[1:0]),
        .size      (size_q),
        .wdata     (wdata_q),
        .lo        (lo_in),
        .hi        (hi_in),
        .uns       (uns_q),
        .lane_data (lane_data),
        .lane_mask (lane_mask),
        .span      (span),
        .rdata     (load_data)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wmask = 4'b0;
        mem_wdata = 32'b0;
        case (state)
            IDLE: if (req_valid) state_n = (req_size == SZ_X) ? RESP : ACC0;
            ACC0: begin
                mem_addr = word0;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wmask = lane_mask[3:0];
                    mem_wdata = lane_data[31:0];
                end
                state_n = span ? ACC1 : RESP;
            end
            ACC1: begin
                mem_addr = word1;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wmask = lane_mask[7:4];
                    mem_wdata = lane_data[63:32];
                end
                state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'b0;
            lo_q      <= 32'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACC0) lo_q <= mem_rdata;
            // Entering RESP straight from IDLE only happens for an illegal size.
            if (state_n == RESP) begin
                rsp_err   <= (state == IDLE);
                rsp_rdata <= (state == IDLE || we_q) ? 32'b0 : load_data;
            end
        end
    end

endmodule
